// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage RV32I pipeline: stalls, bubbles, flushes, freezes and EX forwarding.
// Define HAZARD_PERF_EN to build the load-use / memory-freeze / flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_mem,
    output logic [CNT_W-1:0] perf_flush
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    genvar gi;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic [4:0] idex_rd_q, idex_rd_d;
    logic [4:0] idex_rs1_q, idex_rs1_d;
    logic [4:0] idex_rs2_q, idex_rs2_d;
    logic       idex_rw_q, idex_rw_d;
    logic       idex_mr_q, idex_mr_d;
    logic [4:0] exmem_rd_q, exmem_rd_d;
    logic       exmem_rw_q, exmem_rw_d;
    logic [4:0] memwb_rd_q, memwb_rd_d;
    logic       memwb_rw_q, memwb_rw_d;

    logic at_timeout;
    logic freeze_raw;
    logic lu;

    // The freeze is released in the timeout cycle itself so the abandoned wait costs no extra cycle.
    assign at_timeout = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_VAL);
    assign freeze_raw = mem_req && !mem_ready && !at_timeout;

    assign lu = idex_mr_q && (idex_rd_q != 5'd0) && id_valid &&
                ((id_use_rs1 && (id_rs1 == idex_rd_q)) || (id_use_rs2 && (id_rs2 == idex_rd_q)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (freeze_raw) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Operand forwarding: index 0 is rs1 (fwd_a), index 1 is rs2 (fwd_b); EX/MEM is the younger result.
    logic [4:0] idex_src [2];
    logic [1:0] fwd_sel  [2];

    assign idex_src[0] = idex_rs1_q;
    assign idex_src[1] = idex_rs2_q;

    for (gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] =
            (exmem_rw_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_src[gi])) ? 2'b10 :
            (memwb_rw_q && (memwb_rd_q != 5'd0) && (memwb_rd_q == idex_src[gi])) ? 2'b01 :
                                                                                  2'b00;
    end

    assign fwd_a   = reset ? fwd_sel[0] : 2'b00;
    assign fwd_b   = reset ? fwd_sel[1] : 2'b00;
    assign mem_err = mem_err_q;

    always_comb begin
        idex_rd_d  = idex_rd_q;
        idex_rs1_d = idex_rs1_q;
        idex_rs2_d = idex_rs2_q;
        idex_rw_d  = idex_rw_q;
        idex_mr_d  = idex_mr_q;
        exmem_rd_d = exmem_rd_q;
        exmem_rw_d = exmem_rw_q;
        memwb_rd_d = memwb_rd_q;
        memwb_rw_d = memwb_rw_q;
        if (!freeze_raw) begin
            if (idex_bubble || !id_valid) begin
                idex_rd_d  = 5'd0;
                idex_rs1_d = 5'd0;
                idex_rs2_d = 5'd0;
                idex_rw_d  = 1'b0;
                idex_mr_d  = 1'b0;
            end else begin
                idex_rd_d  = id_rd;
                idex_rs1_d = id_rs1;
                idex_rs2_d = id_rs2;
                idex_rw_d  = id_reg_write;
                idex_mr_d  = id_mem_read;
            end
            exmem_rd_d = idex_rd_q;
            exmem_rw_d = idex_rw_q;
            memwb_rd_d = exmem_rd_q;
            memwb_rw_d = exmem_rw_q;
        end
    end

    // A wait also ends if MEM withdraws its request, so a stale count never raises a false timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready || !mem_req) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (at_timeout) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            idex_rd_q  <= 5'd0;
            idex_rs1_q <= 5'd0;
            idex_rs2_q <= 5'd0;
            idex_rw_q  <= 1'b0;
            idex_mr_q  <= 1'b0;
            exmem_rd_q <= 5'd0;
            exmem_rw_q <= 1'b0;
            memwb_rd_q <= 5'd0;
            memwb_rw_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            idex_rd_q  <= idex_rd_d;
            idex_rs1_q <= idex_rs1_d;
            idex_rs2_q <= idex_rs2_d;
            idex_rw_q  <= idex_rw_d;
            idex_mr_q  <= idex_mr_d;
            exmem_rd_q <= exmem_rd_d;
            exmem_rw_q <= exmem_rw_d;
            memwb_rd_q <= memwb_rd_d;
            memwb_rw_q <= memwb_rw_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             perf_ev  [3];
    logic [CNT_W-1:0] perf_cnt [3];

    assign perf_ev[0] = lu;
    assign perf_ev[1] = pipe_freeze;
    assign perf_ev[2] = ifid_flush;

    for (gi = 0; gi < 3; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (perf_ev[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_cnt[gi] = cnt_q;
    end

    assign perf_lu    = perf_cnt[0];
    assign perf_mem   = perf_cnt[1];
    assign perf_flush = perf_cnt[2];
`else
    assign perf_lu    = '0;
    assign perf_mem   = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: per-cycle expected outputs go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic             ex_branch_taken, mem_req, mem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_err;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] perf_lu, perf_mem, perf_flush;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .pipe_freeze    (pipe_freeze),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .mem_err        (mem_err),
        .perf_lu        (perf_lu),
        .perf_mem       (perf_mem),
        .perf_flush     (perf_flush)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, mem_err}
    wire [9:0] obs = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, mem_err};

    logic [9:0] exp_q [$];
    string      tag_q [$];
    int         total = 0;
    int         bad   = 0;

    function automatic stim_t mk(input logic rst_n, v, input logic [4:0] rs1, rs2, rd,
                                 input logic u1, u2, rw, mr, br, req, rdy);
        return '{rst_n, v, rs1, rs2, rd, u1, u2, rw, mr, br, req, rdy};
    endfunction

    function automatic logic [9:0] ex(input logic pc, wr, fl, bb, fz, input logic [1:0] fa, fb,
                                      input logic er);
        return {pc, wr, fl, bb, fz, fa, fb, er};
    endfunction

    task automatic apply(input stim_t s);
        reset           = s.rst_n;
        id_valid        = s.v;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_rd           = s.rd;
        id_use_rs1      = s.u1;
        id_use_rs2      = s.u2;
        id_reg_write    = s.rw;
        id_mem_read     = s.mr;
        ex_branch_taken = s.br;
        mem_req         = s.req;
        mem_ready       = s.rdy;
    endtask

    task automatic test_reset();
        stim_t      s [3];
        logic [9:0] x [3];
        logic [9:0] want;
        string      tag;
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[0] = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
        s[1] = mk(0, 1, 3, 4, 5, 1, 1, 1, 1, 1, 1, 0);  x[1] = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
        s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[2] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("reset[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
        total++;
        if ({perf_lu, perf_mem, perf_flush} !== '0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d/%0d want=0/0/0", perf_lu, perf_mem, perf_flush);
        end else $display("ok   reset_perf all zero");
    endtask

    task automatic test_load_use();
        stim_t      s [5];
        logic [9:0] x [5];
        logic [9:0] want;
        string      tag;
        s[0] = mk(1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);  x[0] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        s[1] = mk(1, 1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0);  x[1] = ex(0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        s[2] = s[1];                                    x[2] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[3] = ex(1, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        s[4] = s[3];                                    x[4] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("load_use[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    task automatic test_forward();
        stim_t      s [12];
        logic [9:0] x [12];
        logic [9:0] want;
        string      tag;
        stim_t      idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin s[i] = idle; x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0); end
        s[0]  = mk(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0);
        s[1]  = mk(1, 1, 3, 3, 4, 1, 1, 1, 0, 0, 0, 0);
        x[2]  = ex(1, 1, 0, 0, 0, 2'b10, 2'b10, 0);
        s[4]  = mk(1, 1, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0);
        s[5]  = mk(1, 1, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0);
        s[7]  = mk(1, 1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0);
        s[8]  = mk(1, 1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0);
        s[9]  = mk(1, 1, 7, 1, 8, 1, 1, 1, 0, 0, 0, 0);
        x[10] = ex(1, 1, 0, 0, 0, 2'b10, 2'b00, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("forward[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    task automatic test_branch();
        stim_t      s [5];
        logic [9:0] x [5];
        logic [9:0] want;
        string      tag;
        s[0] = mk(1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);  x[0] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        s[1] = mk(1, 1, 5, 1, 6, 1, 1, 1, 0, 1, 0, 0);  x[1] = ex(1, 1, 1, 1, 0, 2'b00, 2'b00, 0);
        s[2] = mk(1, 1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0);  x[2] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[3] = ex(1, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        s[4] = s[3];                                    x[4] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("branch[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    task automatic test_mem_freeze();
        stim_t      s [9];
        logic [9:0] x [9];
        logic [9:0] want;
        string      tag;
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[0] = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
        s[1] = s[0];                                    x[1] = x[0];
        s[2] = mk(1, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0);  x[2] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        s[3] = mk(1, 1, 3, 3, 4, 1, 1, 1, 0, 0, 0, 0);  x[3] = x[2];
        for (int i = 4; i < 7; i++) begin
            s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  x[i] = ex(0, 0, 0, 0, 1, 2'b10, 2'b10, 0);
        end
        s[7] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);  x[7] = ex(1, 1, 1, 1, 0, 2'b10, 2'b10, 0);
        s[8] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[8] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("mem_freeze[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
        total++;
        if (perf_mem !== (PERF_ON ? CNT_W'(3) : CNT_W'(0))) begin
            bad++; $display("FAIL perf_mem got=%0d want=%0d", perf_mem, PERF_ON ? 3 : 0);
        end else $display("ok   perf_mem=%0d", perf_mem);
        total++;
        if ({perf_lu, perf_flush} !== {CNT_W'(0), (PERF_ON ? CNT_W'(1) : CNT_W'(0))}) begin
            bad++; $display("FAIL perf_lu_flush got=%0d/%0d want=0/%0d", perf_lu, perf_flush, PERF_ON ? 1 : 0);
        end else $display("ok   perf_lu=%0d perf_flush=%0d", perf_lu, perf_flush);
    endtask

    task automatic test_timeout();
        stim_t      s [21];
        logic [9:0] x [21];
        logic [9:0] want;
        string      tag;
        for (int i = 0; i < 21; i++) begin
            if (i < 2) begin
                s[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[i] = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
            end else if (i < 2 + MEM_TIMEOUT) begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  x[i] = ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
            end else if (i == 2 + MEM_TIMEOUT) begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
            end else begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 1);
            end
        end
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("timeout[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t      s [22];
        logic [9:0] x [22];
        logic [9:0] want;
        string      tag;
        for (int i = 0; i < 22; i++) begin
            if (i < 3) begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  x[i] = ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
            end else if (i < 5) begin
                s[i] = mk(0, 1, 5, 5, 6, 1, 1, 1, 1, 1, 1, 0);
                x[i] = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, (i == 3) ? 1'b1 : 1'b0);
            end else if (i < 5 + MEM_TIMEOUT) begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  x[i] = ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
            end else if (i == 5 + MEM_TIMEOUT) begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
            end else begin
                s[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 1);
            end
        end
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("reset_mid_wait[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    task automatic test_back_to_back();
        stim_t      s [12];
        logic [9:0] x [12];
        logic [9:0] want;
        string      tag;
        stim_t      idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin s[i] = idle; x[i] = ex(1, 1, 0, 0, 0, 2'b00, 2'b00, 0); end
        s[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  x[0]  = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 1);
        s[1]  = s[0];                                    x[1]  = ex(0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
        s[2]  = mk(1, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0, 0);
        s[3]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);  x[3]  = ex(0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        s[4]  = s[3];
        s[5]  = mk(1, 1, 6, 5, 7, 1, 1, 1, 0, 0, 0, 0);  x[5]  = ex(0, 0, 0, 1, 0, 2'b01, 2'b00, 0);
        s[6]  = s[5];
        x[7]  = ex(1, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        s[8]  = mk(1, 1, 0, 0, 9, 1, 0, 1, 1, 0, 0, 0);
        s[9]  = mk(1, 1, 1, 9, 10, 1, 0, 1, 0, 0, 0, 0);
        x[10] = ex(1, 1, 0, 0, 0, 2'b00, 2'b10, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            apply(s[i]);
            exp_q.push_back(x[i]); tag_q.push_back($sformatf("back_to_back[%0d]", i));
            @(negedge clk);
            want = exp_q.pop_front(); tag = tag_q.pop_front(); total++;
            if (obs !== want) begin bad++; $display("FAIL %s got=%b want=%b", tag, obs, want); end
            else $display("ok   %s obs=%b", tag, obs);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_mem_freeze();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
